// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX stages with stall/flush
// control and saturating stall/redirect performance counters.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              PCSrcE,
  input  logic [31:0]       PCTargetE,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [15:0]       StallCount,
  output logic [15:0]       FlushCount
);

  logic [31:0] pcplus4f;
  logic        flush_d;

  assign pcplus4f = PCF + 32'd4;
  // a redirect resolved in E kills the wrong-path instruction sitting in D
  assign flush_d  = FlushD | PCSrcE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      PCF        <= RESET_PC;
      InstrD     <= '0;
      PCD        <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
      CtrlE      <= '0;
      RD1E       <= '0;
      RD2E       <= '0;
      ImmExtE    <= '0;
      PCE        <= '0;
      PCPlus4E   <= '0;
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
      ValidE     <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (PCSrcE)
        PCF <= PCTargetE;
      else if (!StallF)
        PCF <= pcplus4f;

      if (flush_d) begin
        InstrD   <= '0;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (!StallD) begin
        InstrD   <= InstrF;
        PCD      <= PCF;
        PCPlus4D <= pcplus4f;
        ValidD   <= 1'b1;
      end

      // bubble is all-zero so it can never write the regfile or match forwarding
      if (FlushE) begin
        CtrlE    <= '0;
        RD1E     <= '0;
        RD2E     <= '0;
        ImmExtE  <= '0;
        PCE      <= '0;
        PCPlus4E <= '0;
        Rs1E     <= '0;
        Rs2E     <= '0;
        RdE      <= '0;
        ValidE   <= 1'b0;
      end else begin
        CtrlE    <= CtrlD;
        RD1E     <= RD1D;
        RD2E     <= RD2D;
        ImmExtE  <= ImmExtD;
        PCE      <= PCD;
        PCPlus4E <= PCPlus4D;
        Rs1E     <= Rs1D;
        Rs2E     <= Rs2D;
        RdE      <= RdD;
        ValidE   <= ValidD;
      end

      if (StallF && !PCSrcE && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
      if (PCSrcE && (FlushCount != 16'hFFFF))
        FlushCount <= FlushCount + 16'd1;
    end
  end

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter CTRL_W, default 16, is the width of the decoded control bundle carried D->E.
REQ-003 clk  input  1  is the single clock, and all state updates on its rising edge.
REQ-004 rst  input  1  is the reset, synchronous and active-low; rst=0 at a rising clk edge resets the block.
REQ-005 StallF, StallD  input  1 each  are stall requests for the PC register and the IF/ID register.
REQ-006 FlushD, FlushE  input  1 each  are flush requests for the IF/ID register and the ID/EX register.
REQ-007 PCSrcE  input  1  signals a taken branch or jump resolved in E.
REQ-008 PCTargetE  input  32  is the redirect target.
REQ-009 InstrF  input  32  is the fetched instruction.
REQ-010 CtrlD  input  CTRL_W  is the decoded control bundle.
REQ-011 RD1D, RD2D, ImmExtD  input  32 each  are the register operands and the extended immediate.
REQ-012 Rs1D, Rs2D, RdD  input  5 each  are the register indices.
REQ-013 PCF  output  32  is the current fetch PC.
REQ-014 InstrD, PCD, PCPlus4D  output  32 each, and ValidD  output  1, are the IF/ID contents.
REQ-015 CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  CTRL_W or 32, Rs1E, Rs2E, RdE  output  5, and ValidE  output  1, are the ID/EX contents.
REQ-016 StallCount, FlushCount  output  16 each  are the performance counters.

Function
REQ-017 The PC update priority SHALL be PCSrcE over StallF over normal advance.
- PCSrcE=1: PCF <= PCTargetE.
- Else StallF=1: PCF holds.
- Else: PCF <= PCF+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 PCPlus4F SHALL be the combinational value PCF+4, with 32-bit wrap.
REQ-019 The IF/ID update priority SHALL be flush over stall over load.
- FlushD=1 or PCSrcE=1: InstrD, PCD and PCPlus4D <= 0, and ValidD <= 0.
- Else StallD=1: all IF/ID fields hold, including ValidD.
- Else: load InstrF, PCF and PCPlus4F, and ValidD <= 1.
REQ-020 The ID/EX register SHALL have no stall.
- FlushE=1: every E field <= 0, including CtrlE=0, RdE=0 and ValidE=0, which forms a bubble.
- Else: load the D inputs, with PCE <= PCD, PCPlus4E <= PCPlus4D and ValidE <= ValidD.
REQ-021 A bubble SHALL never carry a non-zero CtrlE or RdE, so it cannot write the register file or trigger forwarding.
REQ-022 Latency SHALL be one cycle per stage: an instruction at PCF at edge N appears in D after edge N+1 and in E after edge N+2 when there are no stalls or flushes.
REQ-023 StallCount SHALL increment by 1 on each edge where StallF=1 and PCSrcE=0, and SHALL saturate at 16'hFFFF.
REQ-024 FlushCount SHALL increment by 1 on each edge where PCSrcE=1, and SHALL saturate at 16'hFFFF.
REQ-025 StallF and StallD asserted together with FlushE SHALL hold F and D and insert a bubble in E; this is the load-use case.
REQ-026 StallD=1 with FlushD=1 SHALL flush D, because flush wins.
REQ-027 PCSrcE=1 with StallF=1 SHALL redirect the PC, not count a stall, and increment FlushCount.
REQ-028 All outputs SHALL be registered except none; no combinational path runs from any input to any output.

Reset
REQ-029 On rst=0 at an edge, the block SHALL set PCF=RESET_PC, set every IF/ID and ID/EX field to 0 (ValidD=ValidE=0), and set StallCount=FlushCount=0.
REQ-030 Reset SHALL override every stall, flush and redirect input in the same cycle.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight stage contents.
REQ-032 After rst returns to 1, the first edge SHALL fetch from RESET_PC+4 and load D from RESET_PC.

Verification
REQ-033 Free run: with RESET_PC=0, no stalls or flushes, and InstrF=PC-indexed pattern, the bench SHALL check that after 3 edges PCF=12, PCD=8, PCE=4, ValidE=1.
REQ-034 Load-use: with PCF=0x20 and PCD=0x1C, assert StallF=StallD=FlushE=1 for 1 cycle; the bench SHALL check PCF=0x20, PCD=0x1C, CtrlE=0, RdE=0, ValidE=0, StallCount=1, then resume with PCE=0x1C.
REQ-035 Redirect: with PCSrcE=1, PCTargetE=0x100 and FlushE=1, the bench SHALL check after the edge PCF=0x100, ValidD=0, InstrD=0, ValidE=0, FlushCount=1.
REQ-036 Simultaneous: with StallF=StallD=1 and PCSrcE=1, the bench SHALL check PCF=PCTargetE, ValidD=0, StallCount unchanged, FlushCount +1.
REQ-037 Saturation and wrap: holding StallF=1 for 65540 cycles SHALL give StallCount=16'hFFFF; PCF=32'hFFFF_FFFC with no stall SHALL give PCF=0 next cycle.
REQ-038 Reset mid-run: rst=0 for 1 edge during a stall SHALL clear all fields and counters, and the next edge SHALL give PCF=RESET_PC+4 and PCD=RESET_PC.
